// File: rtl/whirlpool_pkg.sv
// Shared Whirlpool constants, theta coefficients, FSM encoding and GF(2^8) helpers.
// Byte (i,j) of the 512-bit state is packed row-major with byte (0,0) at the MSBs.
`ifndef WHIRLPOOL_PKG_SV
`define WHIRLPOOL_PKG_SV

// LSB position of state byte A[i][j]
`define WP_BYTE_LSB(i, j) (504 - 8 * (8 * (i) + (j)))

package whirlpool_pkg;

  localparam int unsigned WP_STATE_W = 512;
  localparam int unsigned WP_BYTE_W  = 8;
  localparam int unsigned WP_ROW_W   = 64;
  localparam int unsigned WP_ROWS    = 8;
  localparam int unsigned WP_ROW_IDX_W = 3;

  localparam logic [WP_BYTE_W-1:0] WP_POLY_LO = 8'h1D;

  // c[0..7] of cir(01,01,04,01,08,05,02,09), c[0] in the MSBs
  localparam logic [WP_ROW_W-1:0] WP_THETA_C = 64'h01_01_04_01_08_05_02_09;

  typedef enum logic [1:0] {
    WP_IDLE = 2'd0,
    WP_BUSY = 2'd1,
    WP_DONE = 2'd2
  } wp_theta_state_e;

  function automatic logic [WP_BYTE_W-1:0] wp_xtime(input logic [WP_BYTE_W-1:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? WP_POLY_LO : 8'h00);
  endfunction

  function automatic logic [WP_BYTE_W-1:0] wp_theta_coef(input int unsigned idx);
    return WP_THETA_C[WP_ROW_W - 1 - WP_BYTE_W * (idx % WP_ROWS) -: WP_BYTE_W];
  endfunction

endpackage

`endif

// File: rtl/whirlpool_theta_row.sv
// Combinational theta mixer for one 64-bit state row: b[j] = XOR_k a[k] * c[(j-k) mod 8].
// Only x1/x2/x4/x8 multiples are formed; x5 and x9 are built from them.
module whirlpool_theta_row
  import whirlpool_pkg::*;
(
  input  logic [63:0] row_in,
  output logic [63:0] mix_c
);

  logic [WP_BYTE_W-1:0] a  [WP_ROWS];
  logic [WP_BYTE_W-1:0] m2 [WP_ROWS];
  logic [WP_BYTE_W-1:0] m4 [WP_ROWS];
  logic [WP_BYTE_W-1:0] m8 [WP_ROWS];
  logic [WP_BYTE_W-1:0] acc;

  // Per-byte xtime chain shared by all eight output columns
  always_comb begin
    for (int k = 0; k < int'(WP_ROWS); k++) begin
      a[k]  = row_in[WP_ROW_W - 1 - WP_BYTE_W * k -: WP_BYTE_W];
      m2[k] = wp_xtime(a[k]);
      m4[k] = wp_xtime(m2[k]);
      m8[k] = wp_xtime(m4[k]);
    end
  end

  always_comb begin
    mix_c = '0;
    acc   = '0;
    for (int j = 0; j < int'(WP_ROWS); j++) begin
      acc = '0;
      for (int k = 0; k < int'(WP_ROWS); k++) begin
        case (wp_theta_coef(32'((j - k + 8) % 8)))
          8'h01:   acc = acc ^ a[k];
          8'h02:   acc = acc ^ m2[k];
          8'h04:   acc = acc ^ m4[k];
          8'h05:   acc = acc ^ m4[k] ^ a[k];
          8'h08:   acc = acc ^ m8[k];
          8'h09:   acc = acc ^ m8[k] ^ a[k];
          default: acc = acc;
        endcase
      end
      mix_c[WP_ROW_W - 1 - WP_BYTE_W * j -: WP_BYTE_W] = acc;
    end
  end

endmodule

// File: rtl/whirlpool_wcipher_theta_seq.sv
// Row-serial Whirlpool theta (MixRows): one row mixed in place per cycle, 8-cycle latency.
// Single transaction in flight; the work register doubles as the output register.
module whirlpool_wcipher_theta_seq
  import whirlpool_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_state
);

  wp_theta_state_e state_q, state_d;

  logic [WP_ROW_IDX_W-1:0] row_q, row_d;
  logic [WP_STATE_W-1:0]   work_q, work_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [WP_ROW_W-1:0]     row_sel;
  logic [WP_ROW_W-1:0]     row_mix_c;
  logic                    in_hs;

  assign in_hs     = in_valid && in_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = work_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      WP_IDLE: if (in_hs) state_d = WP_BUSY;
      WP_BUSY: if (row_q == WP_ROW_IDX_W'(WP_ROWS - 1)) state_d = WP_DONE;
      WP_DONE: if (out_ready) state_d = WP_IDLE;
      default: state_d = WP_IDLE;
    endcase
  end

  // Row currently being mixed
  always_comb begin
    row_sel = '0;
    for (int r = 0; r < int'(WP_ROWS); r++) begin
      if (row_q == WP_ROW_IDX_W'(r)) row_sel = work_q[`WP_BYTE_LSB(r, 7) +: WP_ROW_W];
    end
  end

  whirlpool_theta_row u_row (
    .row_in (row_sel),
    .mix_c  (row_mix_c)
  );

  // Capture, in-place row write-back and registered handshake outputs
  always_comb begin
    work_d      = work_q;
    row_d       = row_q;
    in_ready_d  = (state_d == WP_IDLE);
    out_valid_d = (state_d == WP_DONE);
    case (state_q)
      WP_IDLE: begin
        if (in_hs) begin
          work_d = in_state;
          row_d  = '0;
        end
      end
      WP_BUSY: begin
        for (int r = 0; r < int'(WP_ROWS); r++) begin
          if (row_q == WP_ROW_IDX_W'(r)) work_d[`WP_BYTE_LSB(r, 7) +: WP_ROW_W] = row_mix_c;
        end
        row_d = row_q + WP_ROW_IDX_W'(1);
      end
      default: begin
        work_d = work_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q       <= '0;
      work_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      row_q       <= row_d;
      work_q      <= work_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_whirlpool_wcipher_theta_seq.sv
// Bench for whirlpool_wcipher_theta_seq: directed literal vectors, backpressure, reset abort
// and a randomized stream, all checked every cycle against a transaction-level theta model.
module tb_whirlpool_wcipher_theta_seq;

  localparam logic [7:0] TC [8] = '{8'h01, 8'h01, 8'h04, 8'h01, 8'h08, 8'h05, 8'h02, 8'h09};
  localparam int N_RAND = 200;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_state;

  whirlpool_wcipher_theta_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int tmo = 0;
  int sent = 0;
  int recv = 0;
  bit done_req = 0;
  bit lit_en = 0;
  logic [511:0] lit_val = '0;

  // Plain shift-and-add GF(2^8) multiply modulo x^8+x^4+x^3+x^2+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011D << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [511:0] theta(input logic [511:0] s);
    logic [511:0] r;
    logic [7:0]   acc;
    r = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        acc = '0;
        for (int k = 0; k < 8; k++)
          acc = acc ^ gmul(s[511 - 8 * (8 * i + k) -: 8], TC[(j - k + 8) % 8]);
        r[511 - 8 * (8 * i + j) -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32 * i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level model: phase, cycles since capture, queue of expected results
  int           m_phase = 0;
  int           m_cnt = 0;
  bit           m_ready = 0;
  bit           m_live = 0;
  bit           just_rst = 0;
  bit           have_prev = 0;
  logic         p_rst, p_iv, p_ordy;
  logic [511:0] p_is;
  logic [511:0] sb[$];

  always @(negedge clk) begin
    if (have_prev) begin
      if (p_rst) begin
        m_phase  = 0;
        m_ready  = 0;
        sb.delete();
        m_live   = 1;
        just_rst = 1;
      end else begin
        just_rst = 0;
        case (m_phase)
          0: if (p_iv && m_ready) begin
               sb.push_back(theta(p_is));
               m_phase = 1;
               m_cnt   = 0;
             end
          1: begin
               m_cnt++;
               if (m_cnt == 8) m_phase = 2;
             end
          default: if (p_ordy) begin
               void'(sb.pop_front());
               m_phase = 0;
             end
        endcase
        m_ready = (m_phase == 0);
      end
      if (m_live) begin
        chk("in_ready", 512'(in_ready), 512'(m_ready));
        chk("out_valid", 512'(out_valid), 512'(m_phase == 2));
        if (just_rst) chk("out_state_after_reset", out_state, '0);
        if (m_phase == 2 && sb.size() > 0) begin
          chk("out_state_vs_model", out_state, sb[0]);
          if (lit_en) chk("out_state_vs_literal", out_state, lit_val);
        end
      end
    end
    p_rst     = rst;
    p_iv      = in_valid;
    p_ordy    = out_ready;
    p_is      = in_state;
    have_prev = 1;
    if (done_req) begin
      chk("wait_timeouts", 512'(tmo), '0);
      chk("random_sent", 512'(sent), 512'(N_RAND));
      chk("random_received", 512'(recv), 512'(N_RAND));
      chk("scoreboard_empty", 512'(sb.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [511:0] s);
    int n;
    n = 0;
    in_state = s;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) tmo++;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid) tmo++;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic directed(input logic [511:0] s, input logic [511:0] e);
    lit_val = e;
    lit_en  = 1'b1;
    send(s);
    wait_out();
    consume();
    lit_en  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    directed({8'h01, 504'h0}, {64'h0101040108050209, 448'h0});
    directed({192'h0, 64'h0101010101010101, 256'h0}, {192'h0, 64'h0303030303030303, 256'h0});
    directed({8'h80, 504'h0}, {64'h80803A8074BA1DF4, 448'h0});

    // Backpressure with ignored in_valid traffic while DONE
    send(rand512());
    wait_out();
    repeat (5) begin
      in_valid = 1'b1;
      in_state = rand512();
      tick();
    end
    in_valid = 1'b0;
    consume();

    // Reset abort mid-transaction, then a clean transaction
    send(rand512());
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    send(rand512());
    wait_out();
    consume();

    fork
      begin : drv
        bit hs;
        int cyc;
        cyc = 0;
        while (sent < N_RAND && cyc < 20000) begin
          in_valid = ($urandom_range(0, 3) != 0);
          in_state = rand512();
          #1;
          hs = in_valid && in_ready;
          tick();
          if (hs) sent++;
          cyc++;
        end
        in_valid = 1'b0;
      end
      begin : snk
        bit hs;
        int cyc;
        cyc = 0;
        while (recv < N_RAND && cyc < 20000) begin
          out_ready = ($urandom_range(0, 1) != 0);
          #1;
          hs = out_valid && out_ready;
          tick();
          if (hs) recv++;
          cyc++;
        end
        out_ready = 1'b0;
      end
    join

    repeat (3) tick();
    done_req = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/whirlpool_wcipher_theta_seq.md
# whirlpool_wcipher_theta_seq

Sequential, handshaked implementation of the Whirlpool W-cipher linear diffusion layer θ (MixRows). It sits directly downstream of the π column-shift stage and consumes the 8×8-byte state π produces. It multiplies each state row by the circulant matrix cir(01,01,04,01,08,05,02,09) over GF(2⁸), one row per clock, trading area for an 8-cycle latency.

## Interface
- No parameters; the matrix and field polynomial are fixed constants.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  `in_state` holds a valid state.
- `in_ready`  out  1  block can accept a state.
- `in_state`  in  512  input state. Byte Aij is at bits [511-8*(8i+j) -: 8], row-major with A00 at the MSBs.
- `out_valid`  out  1  `out_state` holds a completed θ result.
- `out_ready`  in  1  consumer accepts `out_state`.
- `out_state`  out  512  result. Byte Bij uses the same packing as `in_state`.

## Operation
- Function: Bij = XOR over k=0..7 of Aik·c[(j−k) mod 8], with c = (01,01,04,01,08,05,02,09).
- GF(2⁸) reduction polynomial is x⁸+x⁴+x³+x²+1, so xtime(a) = (a<<1) ^ (a[7] ? 8'h1D : 0).
- Products by 2, 4 and 8 are chained xtime. ·5 = ·4 ^ a. ·9 = ·8 ^ a. No general multiplier.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`&`in_ready`, capture `in_state` into the work register, set row counter `row`=0, go to BUSY.
  - BUSY: each cycle, mix row `row` and write it back in place into the same register. `row` increments. When `row`==7 is written, go to DONE.
  - DONE: `out_valid`=1 and `out_state` = work register. On `out_ready`, go to IDLE.
- `in_ready` is 0 in BUSY and DONE. There is no overlap between transactions.
- `out_state` is held stable while `out_valid`=1 and `out_ready`=0.
- `in_valid` is ignored outside IDLE, and `in_state` changes outside IDLE have no effect.
- Rows not yet processed keep their captured values. Row r is mixed using only its own bytes (no cross-row dependency).
- Reset values: state=IDLE, `row`=0, work register=0, `out_valid`=0, `out_state`=0.
- `in_ready`=0 while `rst` is high, then 1 in the first cycle after release.
- Reset during BUSY or DONE aborts the transaction: the result is discarded and `out_valid` drops on the next edge.

## Timing
- Capture at rising edge t. Rows 0..7 are written at edges t+1..t+8. `out_valid`=1 from edge t+8.
- Latency: 8 cycles from input handshake to `out_valid`.
- DONE→IDLE happens at the edge where `out_ready`=1. `in_ready` rises in the following cycle.
- Maximum throughput is 1 state per 10 cycles when `out_ready` is held high.
- Critical path: one row mixer, i.e. 8 bytes × (3 xtime stages + an 8-input XOR tree). No multicycle paths.

## Structure
- Shared package/header `whirlpool_pkg` holds:
  - `WP_STATE_W`=512 and `WP_BYTE_W`=8.
  - `WP_POLY_LO`=8'h1D.
  - The θ coefficient vector c[0..7].
  - The FSM state encodings (IDLE/BUSY/DONE).
  - The byte-index macro for bus packing.
- One sub-module: `whirlpool_theta_row`, a combinational 64-bit row-in / 64-bit row-out mixer. It is reused by a future fully-parallel θ.
- The top level contains only the FSM, the row counter, the work register and row-select/write-back muxing.

## Test plan
- Single byte A00=01, all other bytes 0 → row 0 out = 01 01 04 01 08 05 02 09, rows 1–7 = 0. `out_valid` rises exactly 8 cycles after the handshake.
- Row 3 all 01, others 0 → every B3j = 03, all other bytes 0.
- A00=80, others 0 → row 0 = 80 80 3A 80 74 BA 1D F4 (checks reduction).
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_state` stable, `in_ready`=0 throughout. Then `out_ready`=1 → IDLE, and `in_ready`=1 the next cycle.
- Assert `rst` at BUSY `row`=4 → next cycle `out_valid`=0, `out_state`=0, state IDLE. A fresh input then completes correctly.
- 200 back-to-back random states with random `in_valid`/`out_ready` → compare against a θ reference model, checking no lost or duplicated outputs.
